// File: rtl/hsv_pkg.sv
// Shared constants and width helpers for the RGB-to-HSV pipeline.
package hsv_pkg;

  localparam logic [2:0] SEC_0 = 3'd0;
  localparam logic [2:0] SEC_1 = 3'd1;
  localparam logic [2:0] SEC_2 = 3'd2;
  localparam logic [2:0] SEC_3 = 3'd3;
  localparam logic [2:0] SEC_4 = 3'd4;
  localparam logic [2:0] SEC_5 = 3'd5;

  // Enabled edges from input sample to output register.
  function automatic int hsv_latency(input int data_w);
    return data_w + 3;
  endfunction

  // Dividend width: 2^W * (6d - 1) needs 2W+3 bits.
  function automatic int hsv_num_w(input int data_w);
    return 2 * data_w + 3;
  endfunction

  // Divisor width: 6d needs W+3 bits.
  function automatic int hsv_den_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/rgb2hsv_pipe_if.sv
// Pixel, timing, threshold and result signals of the RGB-to-HSV converter.
interface rgb2hsv_pipe_if #(parameter int DATA_W = 8);
  logic              ce;
  logic              de_in, hsync_in, vsync_in;
  logic [DATA_W-1:0] red, green, blue;
  logic [DATA_W-1:0] h_lo, h_hi, s_lo, s_hi, v_lo;
  logic [DATA_W-1:0] H, S, V;
  logic              skin_out;
  logic              de_out, hsync_out, vsync_out;

  modport master (
    output ce, de_in, hsync_in, vsync_in, red, green, blue,
           h_lo, h_hi, s_lo, s_hi, v_lo,
    input  H, S, V, skin_out, de_out, hsync_out, vsync_out
  );

  modport slave (
    input  ce, de_in, hsync_in, vsync_in, red, green, blue,
           h_lo, h_hi, s_lo, s_hi, v_lo,
    output H, S, V, skin_out, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/hsv_div_step.sv
// One restoring-division step: decides quotient bit BIT and registers the
// partial remainder, divisor and accumulated quotient for the next step.
module hsv_div_step
  import hsv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BIT    = 0,
  localparam int NUM_W = hsv_num_w(DATA_W),
  localparam int DEN_W = hsv_den_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [NUM_W-1:0]  rem_in,
  input  logic [DEN_W-1:0]  den_in,
  input  logic [DATA_W-1:0] quo_in,
  output logic [NUM_W-1:0]  rem_out,
  output logic [DEN_W-1:0]  den_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [NUM_W-1:0] den_sh;
  logic             take;

  // Trial subtraction; a zero divisor (reset bubble) never takes a bit.
  always_comb begin
    den_sh = NUM_W'(den_in) << BIT;
    take   = (den_in != '0) && (rem_in >= den_sh);
  end

  // Step register: restore or keep the remainder, shift in the new bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_out <= '0;
      den_out <= '0;
      quo_out <= '0;
    end else if (ce) begin
      rem_out <= take ? (rem_in - den_sh) : rem_in;
      den_out <= den_in;
      quo_out <= (quo_in << 1) | DATA_W'(take);
    end
  end

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter with skin-window classifier.
module rgb2hsv_pipe
  import hsv_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst,
  rgb2hsv_pipe_if.slave bus
);

  localparam int NUM_W = hsv_num_w(DATA_W);
  localparam int DEN_W = hsv_den_w(DATA_W);
  localparam int DEPTH = hsv_latency(DATA_W) - 1;
  localparam int TL_W  = DATA_W + 4;
  localparam int B_VS  = DATA_W;
  localparam int B_HS  = DATA_W + 1;
  localparam int B_DE  = DATA_W + 2;
  localparam int B_SAT = DATA_W + 3;

  logic [DATA_W-1:0] c_max, c_min, c_d, c_f;
  logic [2:0]        c_k;
  logic [DATA_W-1:0] s1_d, s1_f;
  logic [2:0]        s1_k;
  logic [TL_W-1:0]   tl [DEPTH];
  logic [DEN_W-1:0]  kdf;
  logic [NUM_W-1:0]  h_num, s_num;
  logic [DEN_W-1:0]  h_den, s_den;
  logic [NUM_W-1:0]  h_rem [DATA_W];
  logic [DEN_W-1:0]  h_dv  [DATA_W];
  logic [DATA_W-1:0] h_quo [DATA_W];
  logic [NUM_W-1:0]  s_rem [DATA_W];
  logic [DEN_W-1:0]  s_dv  [DATA_W];
  logic [DATA_W-1:0] s_quo [DATA_W];
  logic [DATA_W-1:0] h_q, s_q, v_q;
  logic              hue_ok, skin;
  logic              div_unused;

  // Max/min, chroma, hue sector and in-sector fraction of the input pixel.
  always_comb begin
    c_max = bus.red;
    if (!(bus.red >= bus.green && bus.red >= bus.blue))
      c_max = (bus.green >= bus.blue) ? bus.green : bus.blue;
    c_min = bus.red;
    if (bus.green < c_min) c_min = bus.green;
    if (bus.blue < c_min) c_min = bus.blue;
    c_d = c_max - c_min;
    c_k = SEC_0;
    c_f = '0;
    if (bus.red >= bus.green && bus.red >= bus.blue) begin
      if (bus.green >= bus.blue) begin c_k = SEC_0; c_f = bus.green - bus.blue; end
      else begin c_k = SEC_5; c_f = c_d - (bus.blue - bus.green); end
    end else if (bus.green >= bus.blue) begin
      if (bus.blue >= bus.red) begin c_k = SEC_2; c_f = bus.blue - bus.red; end
      else begin c_k = SEC_1; c_f = c_d - (bus.red - bus.blue); end
    end else begin
      if (bus.red >= bus.green) begin c_k = SEC_4; c_f = bus.red - bus.green; end
      else begin c_k = SEC_3; c_f = c_d - (bus.green - bus.red); end
    end
  end

  // Stage 1 register plus the side-band delay line (value, timing, saturation).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_d <= '0;
      s1_f <= '0;
      s1_k <= SEC_0;
      for (int i = 0; i < DEPTH; i++) tl[i] <= '0;
    end else if (bus.ce) begin
      s1_d  <= c_d;
      s1_f  <= c_f;
      s1_k  <= c_k;
      tl[0] <= {(c_min == '0) && (c_max != '0), bus.de_in, bus.hsync_in,
                bus.vsync_in, c_max};
      for (int i = 1; i < DEPTH; i++) tl[i] <= tl[i-1];
    end
  end

  assign kdf = DEN_W'(s1_k) * DEN_W'(s1_d) + DEN_W'(s1_f);

  // Stage 2: dividends and divisors; grey pixels divide 0 by 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_num <= '0;
      h_den <= '0;
      s_num <= '0;
      s_den <= '0;
    end else if (bus.ce) begin
      if (s1_d == '0) begin
        h_num <= '0;
        h_den <= DEN_W'(1);
        s_num <= '0;
        s_den <= DEN_W'(1);
      end else begin
        h_num <= NUM_W'(kdf) << DATA_W;
        h_den <= DEN_W'(s1_d) * DEN_W'(6);
        s_num <= NUM_W'(s1_d) << DATA_W;
        s_den <= DEN_W'(tl[0][DATA_W-1:0]);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_div
      if (gi == 0) begin : g_first
        hsv_div_step #(.DATA_W(DATA_W), .BIT(DATA_W-1)) u_h (
          .clk(clk), .rst(rst), .ce(bus.ce),
          .rem_in(h_num), .den_in(h_den), .quo_in('0),
          .rem_out(h_rem[0]), .den_out(h_dv[0]), .quo_out(h_quo[0]));
        hsv_div_step #(.DATA_W(DATA_W), .BIT(DATA_W-1)) u_s (
          .clk(clk), .rst(rst), .ce(bus.ce),
          .rem_in(s_num), .den_in(s_den), .quo_in('0),
          .rem_out(s_rem[0]), .den_out(s_dv[0]), .quo_out(s_quo[0]));
      end else begin : g_next
        hsv_div_step #(.DATA_W(DATA_W), .BIT(DATA_W-1-gi)) u_h (
          .clk(clk), .rst(rst), .ce(bus.ce),
          .rem_in(h_rem[gi-1]), .den_in(h_dv[gi-1]), .quo_in(h_quo[gi-1]),
          .rem_out(h_rem[gi]), .den_out(h_dv[gi]), .quo_out(h_quo[gi]));
        hsv_div_step #(.DATA_W(DATA_W), .BIT(DATA_W-1-gi)) u_s (
          .clk(clk), .rst(rst), .ce(bus.ce),
          .rem_in(s_rem[gi-1]), .den_in(s_dv[gi-1]), .quo_in(s_quo[gi-1]),
          .rem_out(s_rem[gi]), .den_out(s_dv[gi]), .quo_out(s_quo[gi]));
      end
    end
  endgenerate

  // Final remainders and divisors are not needed past the last step.
  assign div_unused = ^{h_rem[DATA_W-1], h_dv[DATA_W-1],
                        s_rem[DATA_W-1], s_dv[DATA_W-1]};

  // Saturation forcing and the skin window, including the wrapping hue case.
  always_comb begin
    h_q    = h_quo[DATA_W-1];
    s_q    = tl[DEPTH-1][B_SAT] ? '1 : s_quo[DATA_W-1];
    v_q    = tl[DEPTH-1][DATA_W-1:0];
    hue_ok = (bus.h_lo <= bus.h_hi) ? (h_q >= bus.h_lo && h_q <= bus.h_hi)
                                    : (h_q >= bus.h_lo || h_q <= bus.h_hi);
    skin   = hue_ok && (s_q >= bus.s_lo) && (s_q <= bus.s_hi) && (v_q >= bus.v_lo);
  end

  // Output register, aligned with the delayed timing bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.H         <= '0;
      bus.S         <= '0;
      bus.V         <= '0;
      bus.skin_out  <= 1'b0;
      bus.de_out    <= 1'b0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
    end else if (bus.ce) begin
      bus.H         <= h_q;
      bus.S         <= s_q;
      bus.V         <= v_q;
      bus.skin_out  <= skin;
      bus.de_out    <= tl[DEPTH-1][B_DE];
      bus.hsync_out <= tl[DEPTH-1][B_HS];
      bus.vsync_out <= tl[DEPTH-1][B_VS];
    end
  end

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Self-checking bench for rgb2hsv_pipe: directed colours, a ce-toggling
// random stream, threshold changes and a mid-frame reset against a model.
module tb_rgb2hsv_pipe;

  localparam int W   = 8;
  localparam int LAT = 11;

  typedef struct {
    int r, g, b;
    bit de, hs, vs;
    bit has_const;
    int ch, cs, cv;
    bit has_skin;
    int cskin;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_valid = 1'b0;
  int   last_h, last_s, last_v, last_skin, last_de, last_hs, last_vs;

  rgb2hsv_pipe_if #(.DATA_W(W)) bus ();

  rgb2hsv_pipe #(.DATA_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // HSV straight from the definitions, using plain integer arithmetic.
  function automatic void refHsv(input int r, input int g, input int b,
                                 output int h, output int s, output int v);
    int mx, mn, d, k, f;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    v = mx;
    if (d == 0) begin
      h = 0; s = 0;
      return;
    end
    if (r >= g && r >= b) begin
      if (g >= b) begin k = 0; f = g - b; end else begin k = 5; f = d - (b - g); end
    end else if (g >= b) begin
      if (b >= r) begin k = 2; f = b - r; end else begin k = 1; f = d - (r - b); end
    end else begin
      if (r >= g) begin k = 4; f = r - g; end else begin k = 3; f = d - (g - r); end
    end
    h = ((1 << W) * (k * d + f)) / (6 * d);
    s = (d == mx) ? (1 << W) - 1 : ((1 << W) * d) / mx;
  endfunction

  function automatic int refSkin(input int h, input int s, input int v);
    int hl, hh;
    bit hue;
    hl  = int'(bus.h_lo);
    hh  = int'(bus.h_hi);
    hue = (hl <= hh) ? (h >= hl && h <= hh) : (h >= hl || h <= hh);
    return (hue && s >= int'(bus.s_lo) && s <= int'(bus.s_hi) && v >= int'(bus.v_lo)) ? 1 : 0;
  endfunction

  task automatic checkPixel(input pix_t e);
    int h, s, v, sk;
    string id;
    refHsv(e.r, e.g, e.b, h, s, v);
    sk = refSkin(h, s, v);
    id = $sformatf("(%0d,%0d,%0d)", e.r, e.g, e.b);
    checkOutput({"H", id}, 32'(bus.H), h);
    checkOutput({"S", id}, 32'(bus.S), s);
    checkOutput({"V", id}, 32'(bus.V), v);
    checkOutput({"skin", id}, 32'(bus.skin_out), sk);
    checkOutput({"de", id}, 32'(bus.de_out), 32'(e.de));
    checkOutput({"hsync", id}, 32'(bus.hsync_out), 32'(e.hs));
    checkOutput({"vsync", id}, 32'(bus.vsync_out), 32'(e.vs));
    if (e.has_const) begin
      checkOutput({"constH", id}, 32'(bus.H), e.ch);
      checkOutput({"constS", id}, 32'(bus.S), e.cs);
      checkOutput({"constV", id}, 32'(bus.V), e.cv);
    end
    if (e.has_skin) checkOutput({"constSkin", id}, 32'(bus.skin_out), e.cskin);
    last_valid = 1'b1;
    last_h = h; last_s = s; last_v = v; last_skin = sk;
    last_de = e.de; last_hs = e.hs; last_vs = e.vs;
  endtask

  task automatic applyStimulus(input int r, input int g, input int b,
                               input bit de, input bit hs, input bit vs, input bit ce_v,
                               input bit has_const = 1'b0, input int ch = 0,
                               input int cs = 0, input int cv = 0,
                               input bit has_skin = 1'b0, input int cskin = 0);
    pix_t p;
    bus.red = 8'(r); bus.green = 8'(g); bus.blue = 8'(b);
    bus.de_in = de; bus.hsync_in = hs; bus.vsync_in = vs;
    bus.ce = ce_v;
    @(posedge clk);
    #1;
    if (ce_v) begin
      p = '{r: r, g: g, b: b, de: de, hs: hs, vs: vs, has_const: has_const,
            ch: ch, cs: cs, cv: cv, has_skin: has_skin, cskin: cskin};
      exp_q.push_back(p);
      if (exp_q.size() == LAT) checkPixel(exp_q.pop_front());
    end else if (last_valid) begin
      checkOutput("holdH", 32'(bus.H), last_h);
      checkOutput("holdS", 32'(bus.S), last_s);
      checkOutput("holdV", 32'(bus.V), last_v);
      checkOutput("holdSkin", 32'(bus.skin_out), last_skin);
      checkOutput("holdDe", 32'(bus.de_out), last_de);
      checkOutput("holdHsync", 32'(bus.hsync_out), last_hs);
      checkOutput("holdVsync", 32'(bus.vsync_out), last_vs);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "H"}, 32'(bus.H), 0);
    checkOutput({tag, "S"}, 32'(bus.S), 0);
    checkOutput({tag, "V"}, 32'(bus.V), 0);
    checkOutput({tag, "skin"}, 32'(bus.skin_out), 0);
    checkOutput({tag, "de"}, 32'(bus.de_out), 0);
    checkOutput({tag, "hsync"}, 32'(bus.hsync_out), 0);
    checkOutput({tag, "vsync"}, 32'(bus.vsync_out), 0);
  endtask

  initial begin
    bus.ce = 1'b1;
    bus.red = '0; bus.green = '0; bus.blue = '0;
    bus.de_in = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.h_lo = 8'd240; bus.h_hi = 8'd20; bus.s_lo = 8'd50; bus.s_hi = 8'd200; bus.v_lo = 8'd80;
    #1;
    checkAllZero("reset_");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed colours, each compared with its known constants too.
    applyStimulus(50, 100, 250, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 160, 204, 250, 1'b1, 0);
    flush(10);
    applyStimulus(128, 128, 128, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 128);
    applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    applyStimulus(255, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 255, 255);
    applyStimulus(0, 255, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 85, 255, 255);
    applyStimulus(0, 0, 255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 170, 255, 255);
    applyStimulus(255, 0, 255, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 213, 255, 255);
    applyStimulus(255, 100, 80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 175, 255, 1'b1, 1);
    flush(10);

    // Random stream with ce alternating 1,0,1,0.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    flush(10);

    // Non-wrapping hue window.
    bus.h_lo = 8'd0; bus.h_hi = 8'd10;
    applyStimulus(255, 100, 80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 175, 255, 1'b1, 1);
    flush(10);

    // Asynchronous reset with the pipeline full.
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom_range(1, 255), $urandom_range(1, 255), 255, 1'b1, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 checkAllZero("midReset_");
    exp_q.delete();
    last_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("fillDe%0d", i), 32'(bus.de_out), 0);
    end
    flush(LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb2hsv_pipe.md
# rgb2hsv_pipe

Parametrised, fully pipelined RGB-to-HSV converter with an integrated skin-window classifier, sitting between the video input timing stage and the neural skin-detection logic. It accepts one pixel per enabled clock, carries DE/HSYNC/VSYNC alongside the pixel with matching delay, and produces hue, saturation, value and a per-pixel skin flag. Compared with the fixed 8-bit converter, the channel width is generic, hue and saturation are exactly defined pipelined quotients, and the output carries a threshold mask.

## Interface
- DATA_W, 8, bits per colour channel and per H/S/V output (range 4..12).
- clk  in  1  pipeline clock; all registers are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when 0, every pipeline register holds.
- de_in, hsync_in, vsync_in  in  1 each  video timing, sampled with the pixel.
- red, green, blue  in  DATA_W each  input pixel.
- h_lo, h_hi, s_lo, s_hi, v_lo  in  DATA_W each  skin thresholds; quasi-static, sampled at the output stage.
- H, S, V  out  DATA_W each  converted pixel.
- skin_out  out  1  skin classification of the pixel on H/S/V.
- de_out, hsync_out, vsync_out  out  1 each  delayed timing, aligned with H/S/V.

## Operation
- Every sample is converted regardless of de_in; timing bits only travel alongside.
- Definitions: max = max(R,G,B), min = min(R,G,B), d = max − min, and V = max.
- Sector k and fraction f, with priority R > G > B for the maximum:
  - R≥G and R≥B: if G≥B then k=0, f=G−B; otherwise k=5, f=d−(B−G).
  - Else if G≥B (so G>R): if B≥R then k=2, f=B−R; otherwise k=1, f=d−(R−B).
  - Otherwise (B maximum): if R≥G then k=4, f=R−G; otherwise k=3, f=d−(G−R).
- H = floor(2^DATA_W·(k·d+f) / (6·d)).
  - Numerator is at most 6d−1, so the quotient is always below 2^DATA_W and needs no clamp.
- S = floor(2^DATA_W·d / max).
  - When d == max (min = 0, max > 0), S is forced to 2^DATA_W−1.
- d == 0 (grey or black): H = 0 and S = 0. No divide occurs; the divider inputs are forced to numerator 0 and denominator 1.
- Divider: restoring, one quotient bit per stage, MSB first, DATA_W stages, with H and S dividers in parallel.
  - The numerator must be 2·DATA_W+3 bits wide.
- skin_out = hue_ok AND (s_lo ≤ S ≤ s_hi) AND (V ≥ v_lo).
  - If h_lo ≤ h_hi: hue_ok = (h_lo ≤ H ≤ h_hi).
  - If h_lo > h_hi, the window wraps: hue_ok = (H ≥ h_lo OR H ≤ h_hi).
  - Comparisons are unsigned.

## Timing
- Pipeline stages, each advancing only on an edge with ce=1:
  - Stage 1: register max, min, d, k, f, flags and timing.
  - Stage 2: form numerators and denominators.
  - Stages 3..DATA_W+2: one divider step each.
  - Stage DATA_W+3: output register, including skin_out.
- Latency = DATA_W+3 enabled edges, counting the edge that samples the input (11 for DATA_W=8).
- Throughput is one pixel per enabled edge. There is no backpressure and no stall other than ce.
- ce=0 freezes the whole pipeline, and all outputs hold.
- Timing bits are delayed by exactly the same number of stages as the data.
- Reset:
  - rst=1 immediately clears every pipeline register, so all outputs are 0, including skin_out and the timing bits.
  - Reset in the middle of a frame discards all pixels in flight.
  - After rst deasserts, the first valid output appears DATA_W+3 enabled edges after the first sampled input.
- Threshold changes affect pixels that reach the output stage on or after the edge on which the change is sampled. Threshold inputs have no pipeline of their own.

## Structure
- Package hsv_pkg holds:
  - sector constants SEC_0..SEC_5 (3-bit);
  - the function hsv_latency(DATA_W) = DATA_W+3;
  - divider width helpers.
- Sub-module hsv_div_step: one combinational restoring-division step plus its pipeline register and ce, instantiated DATA_W times per divider through a generate loop.
- The top level contains stage 1, stage 2, the two divider chains, the timing delay line and the output comparator.

## Test plan
All scenarios use DATA_W=8, so latency is 11.

- Single pixel (50,100,250) with de/hsync/vsync pulsed for one cycle and ce=1: after 11 edges, H=160, S=204, V=250, and the de/hsync/vsync pulse appears on the same cycle.
- Grey and black: (128,128,128) gives H=0, S=0, V=128. (0,0,0) gives all zeros, with no X propagation.
- Primaries: (255,0,0) gives H=0, S=255, V=255. (0,255,0) gives H=85, S=255. (0,0,255) gives H=170, S=255. (255,0,255) gives H=213.
- Random stream of 1000 pixels with ce toggling 1,0,1,0: the output sequence equals the ce=1 run against the reference model, with de_out alignment intact.
- Skin window with h_lo=240, h_hi=20, s_lo=50, s_hi=200, v_lo=80:
  - (255,100,80) gives H=4, S=175, skin_out=1.
  - (50,100,250) gives skin_out=0.
  - Setting h_lo=0 and h_hi=10 keeps (255,100,80) at skin_out=1.
- rst asserted asynchronously with a full pipeline: outputs go to 0 before the next edge. After release, the first new pixel emerges exactly 11 enabled edges after it is sampled.
